// File: rtl/rv32i_multicycle_controller.sv
// rv32i_multicycle_controller: main FSM and decoders for the multicycle RV32I datapath
//
// Drives the datapath mux selects, the write strobes, alu_control and imm_src.
// A mem_req/mem_ready handshake adds wait states. Illegal opcodes, illegal
// branch funct3 values and timed-out accesses enter a sticky FAULT state,
// which is left only by reset.
//
// Parameters:
//   MEM_TIMEOUT  maximum wait cycles per memory access before FAULT (0 = no timeout)
//   COUNTER_W    width of the perf counters
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-low reset
//   ena_i               0 freezes the FSM and forces all strobes low
//   op_i, funct3_i,     instruction fields instr[6:0], instr[14:12], instr[30]
//   funct7_5_i
//   zero_i, alu_lt_i,   ALU flags: result == 0, signed a<b, unsigned a<b
//   alu_ltu_i
//   mem_ready_i         memory completes the access this cycle
//   mem_req_o           memory access request
//   mem_wr_ena_o        memory write strobe
//   adr_src_o           0=PC, 1=result
//   alu_src_a_o         00=PC, 01=OLD_PC, 10=REG_A, 11=ZERO
//   alu_src_b_o         00=REG_B, 01=IMM, 10=FOUR
//   res_src_o           00=ALU_OUT, 01=DATA, 10=ALU_RESULT
//   imm_src_o           0=I, 1=S, 2=B, 3=J, 4=U
//   alu_control_o       ALU operation
//   pc_write_o          PC register enable
//   ir_write_o          IR and OLD_PC enable
//   reg_write_o         register-file write enable
//   fault_o             sticky fault flag
//
// Optional feature, macro RV32I_PERF_COUNTERS_EN: adds instret_o and
// stall_cycles_o counters of width COUNTER_W.

package rv32i_multicycle_controller_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_control_t;
endpackage

module rv32i_multicycle_controller
    import rv32i_multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int COUNTER_W   = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ena_i,
    input  logic [6:0]   op_i,
    input  logic [2:0]   funct3_i,
    input  logic         funct7_5_i,
    input  logic         zero_i,
    input  logic         alu_lt_i,
    input  logic         alu_ltu_i,
    input  logic         mem_ready_i,
    output logic         mem_req_o,
    output logic         mem_wr_ena_o,
    output logic         adr_src_o,
    output logic [1:0]   alu_src_a_o,
    output logic [1:0]   alu_src_b_o,
    output logic [1:0]   res_src_o,
    output logic [2:0]   imm_src_o,
    output alu_control_t alu_control_o,
    output logic         pc_write_o,
    output logic         ir_write_o,
    output logic         reg_write_o,
`ifdef RV32I_PERF_COUNTERS_EN
    output logic [COUNTER_W-1:0] instret_o,
    output logic [COUNTER_W-1:0] stall_cycles_o,
`endif
    output logic         fault_o
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_LUI, S_BRANCH, S_JAL, S_JALR,
        S_LINK, S_FAULT
    } state_t;

    localparam logic [1:0] A_OLD_PC = 2'b01, A_REG = 2'b10, A_ZERO = 2'b11;
    localparam logic [1:0] B_REG = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
    localparam logic [1:0] R_OUT = 2'b00, R_DATA = 2'b01, R_RESULT = 2'b10;

    // The counter only ever holds 0..MEM_TIMEOUT-1: the wait that would reach
    // MEM_TIMEOUT diverts to FAULT instead.
    localparam int WW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          req, wr, pcw, irw, rw;
    logic          rdy, mem_st, taken, bad;

    function automatic alu_control_t alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_SLTU;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            default: alu_dec = ALU_AND;
        endcase
    endfunction

    // mem_ready only counts while running, so a frozen FSM never acts on it.
    assign rdy    = mem_ready_i & ena_i;
    assign mem_st = state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE};
    assign bad    = funct3_i[2:1] == 2'b01;
    // funct3[0] inverts the condition; funct3[1] picks unsigned over signed.
    assign taken  = funct3_i[2] ? (funct3_i[1] ? alu_ltu_i : alu_lt_i) ^ funct3_i[0]
                                : zero_i ^ funct3_i[0];

    always_comb begin
        imm_src_o = op_i == 7'b0100011 ? 3'd1 :
                    op_i == 7'b1100011 ? 3'd2 :
                    op_i == 7'b1101111 ? 3'd3 :
                    (op_i == 7'b0110111 || op_i == 7'b0010111) ? 3'd4 : 3'd0;
    end

    always_comb begin
        state_d       = state_q;
        req           = 1'b0;
        wr            = 1'b0;
        pcw           = 1'b0;
        irw           = 1'b0;
        rw            = 1'b0;
        adr_src_o     = 1'b0;
        alu_src_a_o   = 2'b00;
        alu_src_b_o   = B_REG;
        res_src_o     = R_OUT;
        alu_control_o = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                req = 1'b1;
                if (rdy) begin
                    irw         = 1'b1;
                    pcw         = 1'b1;
                    alu_src_b_o = B_FOUR;
                    res_src_o   = R_RESULT;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = A_OLD_PC;
                alu_src_b_o = B_IMM;
                case (op_i)
                    7'b0000011, 7'b0100011: state_d = S_MEM_ADR;
                    7'b0110011:             state_d = S_EXEC_R;
                    7'b0010011:             state_d = S_EXEC_I;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    7'b0010111:             state_d = S_ALU_WB;
                    default:                state_d = S_FAULT;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_o = A_REG;
                alu_src_b_o = B_IMM;
                state_d     = op_i == 7'b0000011 ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                req       = 1'b1;
                adr_src_o = 1'b1;
                state_d   = rdy ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                res_src_o = R_DATA;
                rw        = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WRITE: begin
                req       = 1'b1;
                wr        = 1'b1;
                adr_src_o = 1'b1;
                state_d   = rdy ? S_FETCH : S_MEM_WRITE;
            end
            S_EXEC_R: begin
                alu_src_a_o   = A_REG;
                alu_control_o = alu_dec(funct3_i, funct7_5_i);
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o   = A_REG;
                alu_src_b_o   = B_IMM;
                alu_control_o = alu_dec(funct3_i, funct7_5_i & (funct3_i == 3'b101));
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                rw      = 1'b1;
                state_d = S_FETCH;
            end
            S_LUI: begin
                alu_src_a_o = A_ZERO;
                alu_src_b_o = B_IMM;
                state_d     = S_ALU_WB;
            end
            S_BRANCH: begin
                alu_src_a_o   = A_REG;
                alu_control_o = ALU_SUB;
                pcw           = taken & ~bad;
                state_d       = bad ? S_FAULT : S_FETCH;
            end
            S_JAL: begin
                pcw     = 1'b1;
                state_d = S_LINK;
            end
            S_JALR: begin
                alu_src_a_o = A_REG;
                alu_src_b_o = B_IMM;
                res_src_o   = R_RESULT;
                pcw         = 1'b1;
                state_d     = S_LINK;
            end
            S_LINK: begin
                alu_src_a_o = A_OLD_PC;
                alu_src_b_o = B_FOUR;
                res_src_o   = R_RESULT;
                rw          = 1'b1;
                state_d     = S_FETCH;
            end
            default: ;
        endcase
        if (mem_st && !rdy && MEM_TIMEOUT > 0 && wait_q == WAIT_MAX)
            state_d = S_FAULT;
        // Any state change clears the count, so each memory state starts at 0.
        wait_d = state_d != state_q ? '0 : wait_q + WW'(mem_st && !mem_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else if (ena_i) begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_req_o    = req & ena_i & rst_i;
    assign mem_wr_ena_o = wr & ena_i & rst_i;
    assign pc_write_o   = pcw & ena_i & rst_i;
    assign ir_write_o   = irw & ena_i & rst_i;
    assign reg_write_o  = rw & ena_i & rst_i;
    assign fault_o      = state_q == S_FAULT;

`ifdef RV32I_PERF_COUNTERS_EN
    logic [COUNTER_W-1:0] instret_q, instret_d, stall_q, stall_d;

    always_comb begin
        instret_d = instret_q + COUNTER_W'(state_d == S_FETCH &&
                    state_q inside {S_MEM_WB, S_ALU_WB, S_LINK, S_BRANCH, S_MEM_WRITE});
        stall_d   = stall_q + COUNTER_W'(mem_req_o && !mem_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            instret_q <= '0;
            stall_q   <= '0;
        end else if (ena_i) begin
            instret_q <= instret_d;
            stall_q   <= stall_d;
        end
    end

    assign instret_o      = instret_q;
    assign stall_cycles_o = stall_q;
`endif
endmodule

// File: doc/rv32i_multicycle_controller.md
Name: rv32i_multicycle_controller

Overview:
Parametrised main FSM and decoders for the multicycle RV32I datapath. Drives the datapath mux selects, write enables, `alu_control` and `imm_src`. Adds two things the first-generation controller lacks: a `mem_req`/`mem_ready` handshake with wait states and an optional timeout, and a sticky fault state for illegal or timed-out operations. It sits beside the PC, IR, register-file and ALU datapath inside the multicycle core.

Parameters:
- MEM_TIMEOUT, 0, maximum wait cycles per memory access before FAULT; 0 disables the timeout.
- COUNTER_W, 32, width of the perf counters (only used with the optional feature).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- ena  in  1  0 freezes the FSM and forces all write strobes to 0.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- zero  in  1  ALU result == 0.
- alu_lt  in  1  signed a<b.
- alu_ltu  in  1  unsigned a<b.
- mem_ready  in  1  memory has completed the access this cycle.
- mem_req  out  1  memory access request.
- mem_wr_ena  out  1  write strobe.
- adr_src  out  1  0=PC, 1=result.
- alu_src_a  out  2  00=PC, 01=OLD_PC, 10=REG_A, 11=ZERO.
- alu_src_b  out  2  00=REG_B, 01=IMM, 10=FOUR.
- res_src  out  2  00=ALU_OUT, 01=DATA, 10=ALU_RESULT.
- imm_src  out  3  0=I, 1=S, 2=B, 3=J, 4=U.
- alu_control  out  alu_control_t  ALU operation.
- pc_write  out  1  PC register enable.
- ir_write  out  1  IR and OLD_PC enable.
- reg_write  out  1  register-file write enable.
- fault  out  1  sticky fault flag.

Behaviour:
- Reset (rst=0 at a posedge): state=FETCH, fault=0; all strobes are 0 while rst=0.
- All outputs are combinational from the current state and inputs (Moore/Mealy mix).
- Default output values: every strobe 0, alu_control=ALU_ADD, all selects 0.
- imm_src is always decoded from op, in every state:
  - 0000011, 0010011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - 0110111, 0010111 → U
  - any other op → I
- FETCH:
  - mem_req=1, adr_src=0.
  - On mem_ready: ir_write=1, pc_write=1, a=PC, b=FOUR, res_src=ALU_RESULT, next state DECODE.
  - Without mem_ready: hold in FETCH.
- DECODE:
  - a=OLD_PC, b=IMM, ADD; result lands in ALU_OUT as the branch/JAL/AUIPC target.
  - Next state by op:
    - load/store → MEM_ADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - 0010111 → ALU_WB
    - otherwise → FAULT
- MEM_ADR:
  - a=REG_A, b=IMM, ADD.
  - Next: MEM_READ if op=0000011, else MEM_WRITE.
- MEM_READ:
  - mem_req=1, adr_src=1, res_src=ALU_OUT.
  - Next: MEM_WB on mem_ready.
- MEM_WB: res_src=DATA, reg_write=1, next FETCH.
- MEM_WRITE:
  - mem_req=1, mem_wr_ena=1, adr_src=1, res_src=ALU_OUT.
  - Next: FETCH on mem_ready.
- EXEC_R:
  - a=REG_A, b=REG_B, function decode, next ALU_WB.
  - Function decode from funct3:
    - 000 → SUB if funct7_5 (R-type only), else ADD
    - 001 → SLL
    - 010 → SLT
    - 011 → SLTU
    - 100 → XOR
    - 101 → SRA if funct7_5, else SRL
    - 110 → OR
    - 111 → AND
- EXEC_I:
  - Same decode as EXEC_R with b=IMM.
  - funct7_5 is ignored except for funct3=101.
  - Next ALU_WB.
- ALU_WB: res_src=ALU_OUT, reg_write=1, next FETCH.
- LUI: a=ZERO, b=IMM, ADD, next ALU_WB.
- BRANCH:
  - a=REG_A, b=REG_B, SUB, res_src=ALU_OUT.
  - pc_write=taken; next FETCH.
  - taken by funct3:
    - 000 → zero
    - 001 → !zero
    - 100 → alu_lt
    - 101 → !alu_lt
    - 110 → alu_ltu
    - 111 → !alu_ltu
    - 010, 011 → FAULT
- JAL: res_src=ALU_OUT, pc_write=1, next LINK.
- JALR: a=REG_A, b=IMM, ADD, res_src=ALU_RESULT, pc_write=1, next LINK.
- LINK: a=OLD_PC, b=FOUR, res_src=ALU_RESULT, reg_write=1, next FETCH.
- Instruction latency with mem_ready tied high:
  - AUIPC 3 cycles; branch 3.
  - R/I-type, LUI, JAL, JALR, store 4.
  - load 5.
- Wait counter:
  - Clears on entry to each memory state and increments each cycle mem_ready=0.
  - If MEM_TIMEOUT>0 and count reaches MEM_TIMEOUT: next state FAULT.
- FAULT: all strobes 0, fault=1, stays in FAULT until reset.
- ena=0:
  - State and wait counter hold.
  - pc_write, ir_write, reg_write, mem_wr_ena and mem_req are 0.
  - mem_ready is ignored.
- Reset mid-access: FSM returns to FETCH next cycle; mem_req drops while rst=0.

Optional Feature:
- Macro: RV32I_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs instret[COUNTER_W-1:0] and stall_cycles[COUNTER_W-1:0]. Both clear on reset and wrap modulo 2^COUNTER_W.
  - instret increments on every transition into FETCH from a completing state (MEM_WB, ALU_WB, LINK, BRANCH, MEM_WRITE with mem_ready).
  - stall_cycles increments on each ena=1 cycle with mem_req=1 and mem_ready=0.
  - Neither counter increments while ena=0 or in FAULT.
- Undefined: the ports do not exist and there is no counter logic.

Test Plan:
- add (op=0110011, funct3=000, funct7_5=0), mem_ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; alu_control=ALU_ADD in EXEC_R; reg_write=1 in cycle 4 only.
- lw, mem_ready low for 3 cycles in MEM_READ → mem_req held 4 cycles; load completes in 8 cycles; with RV32I_PERF_COUNTERS_EN, stall_cycles=3 and instret=1.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for the first and 0 for the second; each takes 3 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → fault=1 after 4 wait cycles and stays 1; all strobes 0 until rst=0.
- op=1111111 → DECODE→FAULT; op=1100011 with funct3=010 → BRANCH→FAULT.
- ena=0 for 5 cycles mid-EXEC_I, then ena=1 → state unchanged during the freeze, no strobes; instruction completes normally afterwards.
